// File: rtl/lopd_pipe_if.sv
// Valid/ready stream bundle for the pipelined leading-one position detector.
// The slave modport is the detector's view; the master modport is the producer/consumer view.
interface lopd_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    localparam int POS_W = $clog2(WIDTH) + 1;

    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_data;
    logic               i_mode;
    logic [TAG_W-1:0]   i_tag;
    logic               o_valid;
    logic               i_ready;
    logic [POS_W-1:0]   o_pos_one;
    logic               o_zero_flag;
    logic [TAG_W-1:0]   o_tag;

    modport slave (
        input  i_valid, i_data, i_mode, i_tag, i_ready,
        output o_ready, o_valid, o_pos_one, o_zero_flag, o_tag
    );

    modport master (
        output i_valid, i_data, i_mode, i_tag, i_ready,
        input  o_ready, o_valid, o_pos_one, o_zero_flag, o_tag
    );
endinterface

// File: rtl/lopd_pipe.sv
// Two-stage elastic leading-one position / leading-zero count detector.
// Stage 1 scans byte groups locally; stage 2 picks the top non-zero group and formats the result.
module lopd_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    lopd_pipe_if.slave bus
);
    localparam int POS_W = $clog2(WIDTH) + 1;
    localparam int G     = WIDTH / 8;

    logic [G-1:0][2:0]  grpIdx_d, grpIdx_q;
    logic [G-1:0]       grpZero_d, grpZero_q;
    logic               s1Mode_q;
    logic [TAG_W-1:0]   s1Tag_q;
    logic               s1Valid_d, s1Valid_q;

    logic [POS_W-1:0]   pos_d;
    logic [POS_W-1:0]   result_d, result_q;
    logic               zero_d, zero_q;
    logic [TAG_W-1:0]   s2Tag_q;
    logic               s2Valid_d, s2Valid_q;

    logic               ready;
    logic               s1Load;
    logic               s2Load;

    always_comb begin
        for (int g = 0; g < G; g++) begin
            grpZero_d[g] = ~|bus.i_data[g*8 +: 8];
            grpIdx_d[g]  = 3'd0;
            for (int b = 0; b < 8; b++) begin
                if (bus.i_data[g*8 + b]) grpIdx_d[g] = 3'(b);
            end
        end
    end

    // Later (higher) groups overwrite earlier ones, giving priority to the most significant byte.
    always_comb begin
        pos_d = '0;
        for (int g = 0; g < G; g++) begin
            if (!grpZero_q[g]) pos_d = POS_W'(g * 8) | POS_W'(grpIdx_q[g]);
        end
        zero_d = &grpZero_q;
        if (!s1Mode_q) result_d = zero_d ? '0 : pos_d;
        else           result_d = zero_d ? POS_W'(WIDTH) : POS_W'(WIDTH - 1) - pos_d;
    end

    assign ready     = ~i_flush & (~s1Valid_q | ~s2Valid_q | bus.i_ready);
    assign s1Load    = bus.i_valid & ready;
    assign s2Load    = s1Valid_q & (~s2Valid_q | bus.i_ready);
    assign s1Valid_d = ~i_flush & (s1Load | (s1Valid_q & ~s2Load));
    assign s2Valid_d = ~i_flush & (s2Load | (s2Valid_q & ~bus.i_ready));

    // Flush only clears the valids; data registers may keep stale contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grpIdx_q  <= '0;
            grpZero_q <= '0;
            s1Mode_q  <= 1'b0;
            s1Tag_q   <= '0;
            s1Valid_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            s2Tag_q   <= '0;
            s2Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s2Valid_q <= s2Valid_d;
            if (s1Load) begin
                grpIdx_q  <= grpIdx_d;
                grpZero_q <= grpZero_d;
                s1Mode_q  <= bus.i_mode;
                s1Tag_q   <= bus.i_tag;
            end
            if (s2Load) begin
                result_q <= result_d;
                zero_q   <= zero_d;
                s2Tag_q  <= s1Tag_q;
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = s2Valid_q;
    assign bus.o_pos_one   = result_q;
    assign bus.o_zero_flag = zero_q;
    assign bus.o_tag       = s2Tag_q;
endmodule

// File: tb/tb_lopd_pipe.sv
// Self-checking bench for lopd_pipe (WIDTH=32): directed sweeps, streaming, backpressure,
// flush and reset, all compared against a bit-scanning reference model and an in-order scoreboard.
module tb_lopd_pipe;
    localparam int WIDTH = 32;
    localparam int TAG_W = 8;
    localparam int POS_W = $clog2(WIDTH) + 1;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic             zero;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   assertCount = 0;
    int   failCount   = 0;
    int   edgeCnt     = 0;
    int   acceptCount = 0;
    exp_t sb[$];

    lopd_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    lopd_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void refModel(input logic [WIDTH-1:0] d, input logic m,
                                     output logic [POS_W-1:0] p, output logic z);
        int hi;
        hi = -1;
        for (int i = 0; i < WIDTH; i++) if (d[i]) hi = i;
        z = (hi < 0);
        if (!m) p = z ? POS_W'(0) : POS_W'(hi);
        else    p = z ? POS_W'(WIDTH) : POS_W'(WIDTH - 1 - hi);
    endfunction

    task automatic checkEq(input string name, input logic [63:0] obs, input logic [63:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Called just before a rising edge: checks outputs, then advances the model across that edge.
    task automatic checkOutput();
        logic             expReady, expValid;
        logic [POS_W-1:0] p;
        logic             z;
        exp_t             e;
        expReady = !flush && (sb.size() < 2 || bus.i_ready);
        expValid = sb.size() > 0 && sb[0].acc != edgeCnt - 1;
        checkEq("o_ready", 64'(bus.o_ready), 64'(expReady));
        checkEq("o_valid", 64'(bus.o_valid), 64'(expValid));
        if (expValid && bus.o_valid === 1'b1) begin
            e = sb[0];
            checkEq("o_pos_one", 64'(bus.o_pos_one), 64'(e.pos));
            checkEq("o_zero_flag", 64'(bus.o_zero_flag), 64'(e.zero));
            checkEq("o_tag", 64'(bus.o_tag), 64'(e.tag));
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (expValid && bus.i_ready) void'(sb.pop_front());
            if (bus.i_valid && expReady) begin
                refModel(bus.i_data, bus.i_mode, p, z);
                sb.push_back('{pos: p, zero: z, tag: bus.i_tag, acc: edgeCnt});
                acceptCount++;
            end
        end
        edgeCnt++;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                                 input logic v, input logic r, input logic f);
        bus.i_data  = d;
        bus.i_mode  = m;
        bus.i_tag   = t;
        bus.i_valid = v;
        bus.i_ready = r;
        flush       = f;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string name);
        checkEq({name, "_o_valid"}, 64'(bus.o_valid), 64'(0));
        checkEq({name, "_o_pos_one"}, 64'(bus.o_pos_one), 64'(0));
        checkEq({name, "_o_zero_flag"}, 64'(bus.o_zero_flag), 64'(0));
        checkEq({name, "_o_tag"}, 64'(bus.o_tag), 64'(0));
    endtask

    initial begin
        int target;
        int guard;
        rst         = 1'b1;
        flush       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_data  = '0;
        bus.i_mode  = 1'b0;
        bus.i_tag   = '0;
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] index sweep, mode 0");
        for (int n = 0; n < WIDTH; n++) applyStimulus(WIDTH'(1) << n, 1'b0, 8'(n), 1'b1, 1'b1, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 8'hA0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0001_8000, 1'b0, 8'hA1, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0000_0000, 1'b0, 8'hA2, 1'b1, 1'b1, 1'b0);

        $display("[TB] leading-zero count mode");
        applyStimulus(32'h8000_0000, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0000_0001, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0001_0000, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < WIDTH; n++) applyStimulus(WIDTH'(1) << n, 1'b1, 8'(n), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] back-to-back streaming");
        for (int t = 0; t < 100; t++) applyStimulus($urandom, 1'($urandom_range(0, 1)), 8'(t), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] full pipeline under backpressure");
        applyStimulus(32'h0000_0100, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0040_0000, 1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(32'h0000_0003, 1'b0, 8'hC2, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_0003, 1'b0, 8'hC2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] flush with two in flight");
        applyStimulus(32'h0000_0010, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_0020, 1'b0, 8'hD1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_0040, 1'b0, 8'hD2, 1'b1, 1'b1, 1'b1);
        applyStimulus(32'h1000_0000, 1'b1, 8'hD3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] random valid/ready");
        target = acceptCount + 10000;
        guard  = 0;
        while (acceptCount < target && guard < 60000) begin
            applyStimulus($urandom, 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 70), 1'b0);
            guard++;
        end
        checkEq("random_phase_complete", 64'(acceptCount >= target), 64'(1));
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        checkEq("drain_empty", 64'(sb.size()), 64'(0));

        $display("[TB] reset mid-stream");
        applyStimulus(32'h0000_8000, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0080_0000, 1'b0, 8'hE1, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h0000_0004, 1'b1, 8'hE2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
